// File: rtl/bf_control.sv
// bf_control: fetch/execute sequencer for the bfcpu core, including the forward/backward bracket scans.
// Optional feature: define BFCPU_BRACKET_CHECK_EN to raise a sticky err on depth overflow or unmatched brackets.
module bf_control #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               inc_dp,
    input  logic               dec_dp,
    input  logic               inc_d,
    input  logic               dec_d,
    input  logic               out_d,
    input  logic               in_d,
    input  logic               loop_start,
    input  logic               loop_end,
    input  logic               nop,
    input  logic               instr_end,
    input  logic               data_zero,
    input  logic               in_valid,
    input  logic               out_ready,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               pc_dec,
    output logic               dp_inc_o,
    output logic               dp_dec_o,
    output logic               d_inc_o,
    output logic               d_dec_o,
    output logic               d_load,
    output logic               in_ready,
    output logic               out_valid,
    output logic               halted,
    output logic               err,
    output logic [DEPTH_W-1:0] depth
);

`ifdef BFCPU_BRACKET_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_EXEC, S_OUT_WAIT, S_IN_WAIT,
        S_SFETCH, S_SSCAN, S_BFETCH, S_BSCAN, S_HALT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [DEPTH_W-1:0] r_depth;
    logic [DEPTH_W-1:0] w_depth_next;
    logic               r_err;
    logic               w_err_next;

    always_comb begin
        w_state_next = r_state;
        w_depth_next = r_depth;
        w_err_next   = r_err;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_dec       = 1'b0;
        dp_inc_o     = 1'b0;
        dp_dec_o     = 1'b0;
        d_inc_o      = 1'b0;
        d_dec_o      = 1'b0;
        d_load       = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        halted       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                ir_load      = 1'b1;
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                if (instr_end) begin
                    w_state_next = S_HALT;
                end else if (out_d) begin
                    w_state_next = S_OUT_WAIT;
                end else if (in_d) begin
                    w_state_next = S_IN_WAIT;
                end else if (loop_start) begin
                    pc_inc = 1'b1;
                    if (data_zero) begin
                        w_depth_next = DEPTH_ONE;
                        w_state_next = S_SFETCH;
                    end else begin
                        w_state_next = S_FETCH;
                    end
                end else if (loop_end) begin
                    if (!data_zero) begin
                        pc_dec       = 1'b1;
                        w_depth_next = DEPTH_ONE;
                        w_state_next = S_BFETCH;
                    end else begin
                        pc_inc       = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end else begin
                    // Priority chain keeps the datapath to one strobe even if the decode is not one-hot.
                    pc_inc       = 1'b1;
                    w_state_next = S_FETCH;
                    if (nop)         ;
                    else if (inc_dp) dp_inc_o = 1'b1;
                    else if (dec_dp) dp_dec_o = 1'b1;
                    else if (inc_d)  d_inc_o  = 1'b1;
                    else if (dec_d)  d_dec_o  = 1'b1;
                end
            end
            S_OUT_WAIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pc_inc       = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_IN_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    d_load       = 1'b1;
                    pc_inc       = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_SFETCH: begin
                ir_load      = 1'b1;
                w_state_next = S_SSCAN;
            end
            S_SSCAN: begin
                if (instr_end) begin
                    w_state_next = S_HALT;
                    if (CHECK_EN) w_err_next = 1'b1;
                end else if (CHECK_EN && loop_start && (r_depth == DEPTH_MAX)) begin
                    w_err_next   = 1'b1;
                    w_state_next = S_HALT;
                end else begin
                    pc_inc       = 1'b1;
                    w_state_next = S_SFETCH;
                    if (loop_start) begin
                        w_depth_next = r_depth + DEPTH_ONE;
                    end else if (loop_end) begin
                        w_depth_next = r_depth - DEPTH_ONE;
                        if (r_depth == DEPTH_ONE) w_state_next = S_FETCH;
                    end
                end
            end
            S_BFETCH: begin
                ir_load      = 1'b1;
                w_state_next = S_BSCAN;
            end
            S_BSCAN: begin
                if (instr_end) begin
                    w_state_next = S_HALT;
                    if (CHECK_EN) w_err_next = 1'b1;
                end else if (CHECK_EN && loop_end && (r_depth == DEPTH_MAX)) begin
                    w_err_next   = 1'b1;
                    w_state_next = S_HALT;
                end else if (loop_start && (r_depth == DEPTH_ONE)) begin
                    // Matching '[' found: step past it so execution resumes inside the loop body.
                    w_depth_next = '0;
                    pc_inc       = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    pc_dec       = 1'b1;
                    w_state_next = S_BFETCH;
                    if (loop_start)    w_depth_next = r_depth - DEPTH_ONE;
                    else if (loop_end) w_depth_next = r_depth + DEPTH_ONE;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_depth <= w_depth_next;
            r_err   <= w_err_next;
        end
    end

    assign err   = CHECK_EN & r_err;
    assign depth = r_depth;

endmodule

// File: tb/tb_bf_control.sv
// tb_bf_control: drives bf_control inside a small bench-side IR/PC/data-cell model and checks programs
// against hand-derived tables and a behavioural interpreter. Honours BFCPU_BRACKET_CHECK_EN.
module tb_bf_control;
    localparam int DW    = 8;
    localparam int MEMN  = 64;
    localparam int LIMIT = 1500;
`ifdef BFCPU_BRACKET_CHECK_EN
    localparam int EXP_UNM_ERR = 1;
`else
    localparam int EXP_UNM_ERR = 0;
`endif
    localparam logic [7:0] CH_INC = 8'h2B, CH_DEC = 8'h2D, CH_RT = 8'h3E, CH_LT = 8'h3C;
    localparam logic [7:0] CH_OUT = 8'h2E, CH_IN  = 8'h2C, CH_LS = 8'h5B, CH_LE = 8'h5D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, run;
    logic inc_dp, dec_dp, inc_d, dec_d, out_d, in_d, loop_start, loop_end, nop, instr_end, data_zero;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic ir_load, pc_inc, pc_dec, dp_inc_o, dp_dec_o, d_inc_o, d_dec_o, d_load;
    logic in_ready, out_valid, halted, err;
    logic [DW-1:0] depth;

    bf_control #(.DEPTH_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .inc_dp(inc_dp), .dec_dp(dec_dp), .inc_d(inc_d), .dec_d(dec_d),
        .out_d(out_d), .in_d(in_d), .loop_start(loop_start), .loop_end(loop_end), .nop(nop),
        .instr_end(instr_end), .data_zero(data_zero), .in_valid(in_valid), .out_ready(out_ready),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_dec(pc_dec),
        .dp_inc_o(dp_inc_o), .dp_dec_o(dp_dec_o), .d_inc_o(d_inc_o), .d_dec_o(d_dec_o),
        .d_load(d_load), .in_ready(in_ready), .out_valid(out_valid),
        .halted(halted), .err(err), .depth(depth)
    );

    // Bench-side system: program memory, IR, PC, data pointer, cells, I/O.
    logic [7:0] imem [MEMN];
    logic [7:0] inb [16];
    int         dly [64];
    logic [7:0] ir;
    int         pc;
    logic [3:0] dp;
    logic [7:0] cells [16];
    int         io_idx, in_idx, wcnt = 0;
    logic [7:0] out_q [$];
    int         ddec_pc [$];
    int n_inrdy, n_outval, n_dload, n_pcinc_wait, n_dinc, n_ddec, n_dpinc, n_irload, max_depth;
    int viol = 0;

    assign inc_dp     = (ir == CH_RT);
    assign dec_dp     = (ir == CH_LT);
    assign inc_d      = (ir == CH_INC);
    assign dec_d      = (ir == CH_DEC);
    assign out_d      = (ir == CH_OUT);
    assign in_d       = (ir == CH_IN);
    assign loop_start = (ir == CH_LS);
    assign loop_end   = (ir == CH_LE);
    assign instr_end  = (ir == 8'h00);
    assign nop        = !(inc_dp || dec_dp || inc_d || dec_d || out_d || in_d || loop_start || loop_end || instr_end);
    assign data_zero  = (cells[dp] == 8'h00);

    always @(posedge clk) begin
        if ((pc_inc && pc_dec) || ($countones({dp_inc_o, dp_dec_o, d_inc_o, d_dec_o, d_load}) > 1))
            viol <= viol + 1;
        if (!rst_n) begin
            ir <= 8'h00; pc <= 0; dp <= 4'd0; io_idx <= 0; in_idx <= 0;
            for (int i = 0; i < 16; i++) cells[i] <= 8'h00;
            out_q.delete(); ddec_pc.delete();
            n_inrdy <= 0; n_outval <= 0; n_dload <= 0; n_pcinc_wait <= 0; n_dinc <= 0;
            n_ddec <= 0; n_dpinc <= 0; n_irload <= 0; max_depth <= 0;
        end else begin
            if (ir_load) ir <= (pc >= 0 && pc < MEMN) ? imem[pc] : 8'h00;
            if (pc_inc) pc <= pc + 1;
            if (pc_dec) pc <= pc - 1;
            if (dp_inc_o) begin dp <= dp + 4'd1; n_dpinc <= n_dpinc + 1; end
            if (dp_dec_o) dp <= dp - 4'd1;
            if (d_inc_o) begin cells[dp] <= cells[dp] + 8'd1; n_dinc <= n_dinc + 1; end
            if (d_dec_o) begin cells[dp] <= cells[dp] - 8'd1; n_ddec <= n_ddec + 1; ddec_pc.push_back(pc); end
            if (d_load) begin cells[dp] <= inb[in_idx % 16]; n_dload <= n_dload + 1; end
            if (in_valid && in_ready) begin io_idx <= io_idx + 1; in_idx <= in_idx + 1; end
            if (out_valid && out_ready) begin io_idx <= io_idx + 1; out_q.push_back(cells[dp]); end
            if (in_ready) n_inrdy <= n_inrdy + 1;
            if (out_valid) n_outval <= n_outval + 1;
            if (pc_inc && (in_ready || out_valid)) n_pcinc_wait <= n_pcinc_wait + 1;
            if (ir_load) n_irload <= n_irload + 1;
            if (int'(depth) > max_depth) max_depth <= int'(depth);
        end
    end

    // I/O partner: answers a pending request after dly[] wait cycles.
    always @(negedge clk) begin
        if (in_ready || out_valid) begin
            in_valid  <= in_ready  && (wcnt >= dly[io_idx % 64]);
            out_ready <= out_valid && (wcnt >= dly[io_idx % 64]);
            wcnt      <= wcnt + 1;
        end else begin
            in_valid  <= 1'b0;
            out_ready <= 1'b0;
            wcnt      <= 0;
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_packed(input bit [127:0] pv);
        int j = 0;
        for (int i = 0; i < MEMN; i++) imem[i] = 8'h00;
        for (int b = 15; b >= 0; b--) begin
            if (pv[b*8 +: 8] != 8'h00) begin imem[j] = pv[b*8 +: 8]; j++; end
        end
    endtask

    task automatic start_prog();
        rst_n = 1'b0; run = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk) run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
    endtask

    task automatic run_dut(output int ncyc);
        start_prog();
        ncyc = 0;
        while (ncyc < LIMIT + 20) begin
            @(posedge clk); #1;
            ncyc++;
            if (halted) break;
        end
    endtask

    // Behavioural interpreter: executes the program and charges cycles per instruction class.
    logic [7:0] m_out [$];
    logic [7:0] m_cells [16];
    int m_cyc, m_pc, m_unm, m_ok;

    task automatic ref_run();
        int p = 0, d = 0, io = 0, ii = 0, k, lvl;
        bit done = 0;
        logic [7:0] c;
        m_out.delete();
        for (int i = 0; i < 16; i++) m_cells[i] = 8'h00;
        m_cyc = 0; m_unm = 0;
        while (!done && m_cyc < LIMIT) begin
            c = imem[p];
            if (c == 8'h00) begin
                m_cyc += 2; done = 1;
            end else if (c == CH_INC) begin m_cells[d] += 8'd1; p++; m_cyc += 2;
            end else if (c == CH_DEC) begin m_cells[d] -= 8'd1; p++; m_cyc += 2;
            end else if (c == CH_RT)  begin d = (d + 1) & 15;    p++; m_cyc += 2;
            end else if (c == CH_LT)  begin d = (d + 15) & 15;   p++; m_cyc += 2;
            end else if (c == CH_OUT) begin
                m_out.push_back(m_cells[d]); m_cyc += 3 + dly[io % 64]; io++; p++;
            end else if (c == CH_IN) begin
                m_cells[d] = inb[ii % 16]; ii++; m_cyc += 3 + dly[io % 64]; io++; p++;
            end else if (c == CH_LS && m_cells[d] == 8'h00) begin
                k = p; lvl = 1;
                while (lvl > 0 && k < MEMN - 1) begin
                    k++;
                    if (imem[k] == 8'h00) break;
                    if (imem[k] == CH_LS) lvl++;
                    else if (imem[k] == CH_LE) lvl--;
                end
                m_cyc += 2 + 2 * (k - p);
                if (imem[k] == 8'h00) begin p = k; m_unm = 1; done = 1; end
                else p = k + 1;
            end else if (c == CH_LE && m_cells[d] != 8'h00) begin
                k = p; lvl = 1;
                while (lvl > 0 && k > 0) begin
                    k--;
                    if (imem[k] == CH_LS) lvl--;
                    else if (imem[k] == CH_LE) lvl++;
                end
                m_cyc += 2 + 2 * (p - k);
                p = k + 1;
            end else begin
                p++; m_cyc += 2;
            end
        end
        m_pc = p; m_ok = done;
    endtask

    task automatic gen_prog();
        int len, open = 0, j = 0, r;
        for (int i = 0; i < MEMN; i++) imem[i] = 8'h00;
        len = $urandom_range(4, 20);
        for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: imem[j] = CH_INC;
                2, 9: imem[j] = CH_DEC;
                3: imem[j] = CH_RT;
                4: imem[j] = CH_LT;
                5: imem[j] = CH_OUT;
                6: imem[j] = CH_IN;
                7: begin imem[j] = CH_LS; open++; end
                default: if (open > 0) begin imem[j] = CH_LE; open--; end else imem[j] = CH_INC;
            endcase
            j++;
        end
        while (open > 0) begin imem[j] = CH_LE; j++; open--; end
        for (int i = 0; i < 16; i++) inb[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 64; i++) dly[i] = $urandom_range(0, 3);
    endtask

    typedef struct {
        bit [127:0] prog;
        logic [7:0] inbyte;
        int dl;
        int n_out;
        int lastv;
        int pcf;
        int cyc;
        int errv;
    } vec_t;
    vec_t tv [8];

    initial begin
        int nc, w, tries;
        tv[0] = '{"+>+.",         8'h00, 0, 1, 1,   4,  11, 0};
        tv[1] = '{",.",           8'h5A, 5, 1, 90,  2,  18, 0};
        tv[2] = '{"[+[-]+]-.",    8'h00, 0, 1, 255, 9,  21, 0};
        tv[3] = '{"+[-]",         8'h00, 0, 0, 0,   4,  10, 0};
        tv[4] = '{"++[-].",       8'h00, 0, 1, 0,   6,  23, 0};
        tv[5] = '{"[",            8'h00, 0, 0, 0,   1,  4,  EXP_UNM_ERR};
        tv[6] = '{"++[>+++<-]>.", 8'h00, 0, 1, 6,   12, 55, 0};
        tv[7] = '{"+x.",          8'h00, 0, 1, 1,   3,  9,  0};

        rst_n = 1'b0; run = 1'b0;
        for (int i = 0; i < MEMN; i++) imem[i] = 8'h00;
        for (int i = 0; i < 16; i++) inb[i] = 8'h00;
        for (int i = 0; i < 64; i++) dly[i] = 0;
        #12;
        chk("reset_outputs", int'({ir_load, pc_inc, pc_dec, dp_inc_o, dp_dec_o, d_inc_o, d_dec_o,
                                   d_load, in_ready, out_valid, halted, err}), 0);
        chk("reset_depth", int'(depth), 0);

        for (int t = 0; t < 8; t++) begin
            load_packed(tv[t].prog);
            for (int i = 0; i < 16; i++) inb[i] = tv[t].inbyte;
            for (int i = 0; i < 64; i++) dly[i] = tv[t].dl;
            run_dut(nc);
            $display("vec %0d: cycles %0d pc %0d outputs %0d err %0d", t, nc, pc, out_q.size(), err);
            chk($sformatf("vec%0d_halted", t), int'(halted), 1);
            chk($sformatf("vec%0d_err", t), int'(err), tv[t].errv);
            chk($sformatf("vec%0d_pc", t), pc, tv[t].pcf);
            chk($sformatf("vec%0d_cycles", t), nc, tv[t].cyc);
            chk($sformatf("vec%0d_nout", t), out_q.size(), tv[t].n_out);
            if (tv[t].n_out > 0 && out_q.size() > 0)
                chk($sformatf("vec%0d_outbyte", t), int'(out_q[out_q.size()-1]), tv[t].lastv);
        end

        // Strobe sequence and single-cycle output handshake.
        load_packed("+>+.");
        for (int i = 0; i < 64; i++) dly[i] = 0;
        run_dut(nc);
        $display("seq +>+.: d_inc %0d dp_inc %0d out_valid cycles %0d", n_dinc, n_dpinc, n_outval);
        chk("seq0_d_inc", n_dinc, 2);
        chk("seq0_dp_inc", n_dpinc, 1);
        chk("seq0_out_valid_cycles", n_outval, 1);

        // Delayed input: in_ready held through the wait, load/step only on the handshake.
        load_packed(",");
        for (int i = 0; i < 16; i++) inb[i] = 8'h33;
        for (int i = 0; i < 64; i++) dly[i] = 5;
        run_dut(nc);
        $display("seq ,: in_ready cycles %0d d_load %0d cell0 %0d", n_inrdy, n_dload, cells[0]);
        chk("seq1_in_ready_cycles", n_inrdy, 6);
        chk("seq1_d_load", n_dload, 1);
        chk("seq1_pc_inc_in_wait", n_pcinc_wait, 1);
        chk("seq1_cell0", int'(cells[0]), 8'h33);

        // Forward skip over nested loop.
        load_packed("[+[-]+]-");
        for (int i = 0; i < 64; i++) dly[i] = 0;
        run_dut(nc);
        $display("seq skip: max depth %0d d_inc %0d d_dec %0d", max_depth, n_dinc, n_ddec);
        chk("seq2_max_depth", max_depth, 2);
        chk("seq2_no_d_inc", n_dinc, 0);
        chk("seq2_d_dec", n_ddec, 1);
        if (ddec_pc.size() > 0) chk("seq2_resume_pc", ddec_pc[0], 7);

        // Backward return to just after '['.
        load_packed("++[-]");
        run_dut(nc);
        $display("seq back: d_dec %0d max depth %0d", n_ddec, max_depth);
        chk("seq3_d_dec", n_ddec, 2);
        chk("seq3_max_depth", max_depth, 1);
        if (ddec_pc.size() > 1) chk("seq3_return_pc", ddec_pc[1], 3);
        chk("seq3_halted", int'(halted), 1);

        // Reset asserted while waiting on the output sink.
        load_packed(".");
        for (int i = 0; i < 64; i++) dly[i] = 100;
        start_prog();
        w = 0;
        while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
        chk("seq4_out_valid_seen", int'(out_valid), 1);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        $display("seq reset: out_valid %0d depth %0d halted %0d", out_valid, depth, halted);
        chk("seq4_out_valid_drop", int'(out_valid), 0);
        chk("seq4_depth", int'(depth), 0);
        chk("seq4_halted", int'(halted), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("seq4_idle_no_fetch", n_irload, 0);
        chk("seq4_idle_out_valid", int'(out_valid), 0);

        // Randomised programs against the interpreter.
        for (int t = 0; t < 20; t++) begin
            tries = 0;
            do begin gen_prog(); ref_run(); tries++; end while ((!m_ok || m_unm != 0) && tries < 50);
            if (!m_ok || m_unm != 0) continue;
            run_dut(nc);
            $display("rand %0d: cycles %0d (model %0d) pc %0d outputs %0d", t, nc, m_cyc, pc, out_q.size());
            chk($sformatf("rand%0d_halted", t), int'(halted), 1);
            chk($sformatf("rand%0d_err", t), int'(err), 0);
            chk($sformatf("rand%0d_pc", t), pc, m_pc);
            chk($sformatf("rand%0d_cycles", t), nc, m_cyc);
            chk($sformatf("rand%0d_nout", t), out_q.size(), m_out.size());
            for (int i = 0; i < m_out.size() && i < out_q.size(); i++)
                chk($sformatf("rand%0d_out%0d", t, i), int'(out_q[i]), int'(m_out[i]));
            for (int i = 0; i < 16; i++)
                chk($sformatf("rand%0d_cell%0d", t, i), int'(cells[i]), int'(m_cells[i]));
        end

        chk("strobe_exclusivity", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
